neuron_scheduler: RTL

NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

---
 rtl/neuron_scheduler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/neuron_scheduler.sv
// Walks N_NEURONS v/w/i state entries through one shared external datapath per timestep.
// A timestep takes N_NEURONS+1 cycles plus one cycle per EMIT cycle; a spike holds the walk until spk_ready.
module neuron_scheduler #(
    parameter int                     N_NEURONS = 16,
    parameter int                     W         = 16,
    parameter logic signed [W-1:0]    V_TH      = 16'sd4096,
    parameter logic signed [W-1:0]    V_RESET   = 16'sd0,
    parameter logic signed [W-1:0]    W_JUMP    = 16'sd1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    input  logic                             i_wr_en,
    input  logic [$clog2(N_NEURONS)-1:0]     i_wr_addr,
    input  logic signed [W-1:0]              i_wr_data,
    output logic signed [W-1:0]              dp_v,
    output logic signed [W-1:0]              dp_w,
    output logic signed [W-1:0]              dp_i,
    input  logic signed [W-1:0]              dp_v_next,
    input  logic signed [W-1:0]              dp_w_next,
    output logic                             spk_valid,
    input  logic                             spk_ready,
    output logic [$clog2(N_NEURONS)-1:0]     spk_id
);
    localparam int            AW   = $clog2(N_NEURONS);
    localparam logic [AW-1:0] LAST = AW'(N_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, RUN, EMIT, DONE} state_t;

    state_t              r_state;
    logic [AW-1:0]       r_idx;
    logic                r_busy;
    logic                r_done;
    logic                r_spk_valid;
    logic [AW-1:0]       r_spk_id;
    logic signed [W-1:0] r_v [N_NEURONS];
    logic signed [W-1:0] r_w [N_NEURONS];
    logic signed [W-1:0] r_i [N_NEURONS];

    logic                w_spike;
    logic [W:0]          w_w_sum;
    logic                w_w_ovf;
    logic signed [W-1:0] w_w_sat;

    assign dp_v      = r_v[r_idx];
    assign dp_w      = r_w[r_idx];
    assign dp_i      = r_i[r_idx];
    assign busy      = r_busy;
    assign done      = r_done;
    assign spk_valid = r_spk_valid;
    assign spk_id    = r_spk_id;

    assign w_spike = (dp_v_next >= V_TH);

    // One extra bit catches overflow of the post-spike adaptation increment.
    assign w_w_sum = {dp_w_next[W-1], dp_w_next} + {W_JUMP[W-1], W_JUMP};
    assign w_w_ovf = (w_w_sum[W] != w_w_sum[W-1]);
    assign w_w_sat = !w_w_ovf   ? w_w_sum[W-1:0] :
                     w_w_sum[W] ? {1'b1, {(W-1){1'b0}}} :
                                  {1'b0, {(W-1){1'b1}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_spk_valid <= 1'b0;
            r_spk_id    <= '0;
            for (int k = 0; k < N_NEURONS; k++) begin
                r_v[k] <= '0;
                r_w[k] <= '0;
                r_i[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (i_wr_en) begin
                r_i[i_wr_addr] <= i_wr_data;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_spike) begin
                        r_v[r_idx]  <= V_RESET;
                        r_w[r_idx]  <= w_w_sat;
                        r_spk_valid <= 1'b1;
                        r_spk_id    <= r_idx;
                        r_state     <= EMIT;
                    end else begin
                        r_v[r_idx] <= dp_v_next;
                        r_w[r_idx] <= dp_w_next;
                        if (r_idx == LAST) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // Event stays registered and stable until the consumer takes it.
                    if (spk_ready) begin
                        r_spk_valid <= 1'b0;
                        if (r_idx == LAST) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= RUN;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
